// File: rtl/tlb_ctrl_pkg.sv
// Shared constants, op encodings and FSM state type for the TLB instruction sequencer.
package tlb_ctrl_pkg;

    localparam int unsigned TLB_ENTRIES = 32;
    localparam int unsigned TLB_IDXBITS = 5;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StDone = 2'b10
    } state_e;

    // Both write ops share op_code[1] = 1.
    function automatic logic op_is_write(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/tlb_random.sv
// CP0 Random register: free-running down-counter that wraps from Wired back to ENTRIES-1.
module tlb_random
    import tlb_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES = TLB_ENTRIES,
    parameter int unsigned IDXBITS = TLB_IDXBITS
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wired_we,
    input  logic [IDXBITS-1:0] cp0_wired,
    output logic [IDXBITS-1:0] random
);

    localparam logic [IDXBITS-1:0] TOP = IDXBITS'(ENTRIES - 1);

    logic [IDXBITS-1:0] random_d;

    // The <= compare also pins Random at TOP when Wired is at or above TOP.
    always_comb begin
        random_d = random - IDXBITS'(1);
        if (wired_we) begin
            random_d = TOP;
        end else if (random <= cp0_wired) begin
            random_d = TOP;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            random <= TOP;
        end else begin
            random <= random_d;
        end
    end

endmodule

// File: rtl/tlb_ctrl.sv
// Executes TLBP/TLBR/TLBWI/TLBWR against the TLB array with a fixed IDLE->EXEC->DONE sequence.
module tlb_ctrl
    import tlb_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES = TLB_ENTRIES,
    parameter int unsigned IDXBITS = TLB_IDXBITS
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               op_valid,
    input  logic [1:0]         op_code,
    output logic               op_ready,
    output logic               op_done,

    input  logic [IDXBITS-1:0] cp0_index,
    input  logic [IDXBITS-1:0] cp0_wired,
    input  logic               wired_we,
    output logic [IDXBITS-1:0] random,

    output logic               tlb_write,
    output logic [IDXBITS-1:0] tlb_idx,
    input  logic [31:0]        read_hi,
    input  logic [31:0]        read_lo0,
    input  logic [31:0]        read_lo1,
    input  logic [11:0]        read_mask,
    input  logic [31:0]        probe_index,

    output logic               idx_we,
    output logic [31:0]        res_index,
    output logic               rd_we,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo0,
    output logic [31:0]        res_lo1,
    output logic [11:0]        res_mask
);

    state_e     state;
    logic [1:0] op_q;

    tlb_random #(
        .ENTRIES (ENTRIES),
        .IDXBITS (IDXBITS)
    ) u_random (
        .clk       (clk),
        .resetn    (resetn),
        .wired_we  (wired_we),
        .cp0_wired (cp0_wired),
        .random    (random)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= StIdle;
            op_q      <= OP_TLBP;
            op_ready  <= 1'b1;
            op_done   <= 1'b0;
            tlb_write <= 1'b0;
            tlb_idx   <= '0;
            idx_we    <= 1'b0;
            rd_we     <= 1'b0;
            res_index <= '0;
            res_hi    <= '0;
            res_lo0   <= '0;
            res_lo1   <= '0;
            res_mask  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (op_valid) begin
                        op_q      <= op_code;
                        // TLBWR takes Random as seen at acceptance, before any wired_we reload.
                        tlb_idx   <= (op_code == OP_TLBWR) ? random : cp0_index;
                        tlb_write <= op_is_write(op_code);
                        op_ready  <= 1'b0;
                        state     <= StExec;
                    end
                end
                StExec: begin
                    tlb_write <= 1'b0;
                    op_done   <= 1'b1;
                    idx_we    <= (op_q == OP_TLBP);
                    rd_we     <= (op_q == OP_TLBR);
                    if (op_q == OP_TLBP) begin
                        res_index <= probe_index;
                    end
                    if (op_q == OP_TLBR) begin
                        res_hi   <= read_hi;
                        res_lo0  <= read_lo0;
                        res_lo1  <= read_lo1;
                        res_mask <= read_mask;
                    end
                    state <= StDone;
                end
                StDone: begin
                    op_done  <= 1'b0;
                    idx_we   <= 1'b0;
                    rd_we    <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= StIdle;
                end
                default: begin
                    state     <= StIdle;
                    op_ready  <= 1'b1;
                    op_done   <= 1'b0;
                    tlb_write <= 1'b0;
                    idx_we    <= 1'b0;
                    rd_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Self-checking bench for tlb_ctrl: per-feature tasks, expected results queued at issue time.
module tb_tlb_ctrl;
    import tlb_ctrl_pkg::*;

    localparam int N = 32;
    localparam int W = 5;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          op_valid = 1'b0;
    logic [1:0]    op_code = 2'b00;
    logic          op_ready;
    logic          op_done;
    logic [W-1:0]  cp0_index = '0;
    logic [W-1:0]  cp0_wired = '0;
    logic          wired_we = 1'b0;
    logic [W-1:0]  random;
    logic          tlb_write;
    logic [W-1:0]  tlb_idx;
    logic [31:0]   read_hi = '0;
    logic [31:0]   read_lo0 = '0;
    logic [31:0]   read_lo1 = '0;
    logic [11:0]   read_mask = '0;
    logic [31:0]   probe_index = '0;
    logic          idx_we;
    logic [31:0]   res_index;
    logic          rd_we;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo0;
    logic [31:0]   res_lo1;
    logic [11:0]   res_mask;

    tlb_ctrl #(
        .ENTRIES (N),
        .IDXBITS (W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_ready    (op_ready),
        .op_done     (op_done),
        .cp0_index   (cp0_index),
        .cp0_wired   (cp0_wired),
        .wired_we    (wired_we),
        .random      (random),
        .tlb_write   (tlb_write),
        .tlb_idx     (tlb_idx),
        .read_hi     (read_hi),
        .read_lo0    (read_lo0),
        .read_lo1    (read_lo1),
        .read_mask   (read_mask),
        .probe_index (probe_index),
        .idx_we      (idx_we),
        .res_index   (res_index),
        .rd_we       (rd_we),
        .res_hi      (res_hi),
        .res_lo0     (res_lo0),
        .res_lo1     (res_lo1),
        .res_mask    (res_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
        logic [11:0] mask;
        logic        idx_we;
        logic        rd_we;
    } exp_t;

    exp_t sb[$];
    exp_t m;      // architectural result registers as the bench expects them
    int n_checks = 0;
    int n_fail = 0;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one op and returns in cycle 1 (EXEC); expected DONE-cycle results are queued.
    task automatic issue(input logic [1:0] code, input logic [W-1:0] idx);
        exp_t e;
        int t = 0;
        while (!op_ready && t < 20) begin
            step();
            t++;
        end
        if (!op_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: op_ready=%b, required 1", op_ready);
        end
        if (code == OP_TLBP) m.index = probe_index;
        if (code == OP_TLBR) begin
            m.hi   = read_hi;
            m.lo0  = read_lo0;
            m.lo1  = read_lo1;
            m.mask = read_mask;
        end
        e        = m;
        e.idx_we = (code == OP_TLBP);
        e.rd_we  = (code == OP_TLBR);
        sb.push_back(e);
        op_valid  = 1'b1;
        op_code   = code;
        cp0_index = idx;
        step();
        op_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({op_ready, op_done, tlb_write, idx_we, rd_we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 10000",
                     {op_ready, op_done, tlb_write, idx_we, rd_we});
        end
        n_checks++;
        if (random !== W'(N - 1) || tlb_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_random_idx: got random=%0d idx=%0d, required 31/0", random, tlb_idx);
        end
        n_checks++;
        if ({res_index, res_hi, res_lo0, res_lo1, res_mask} !== '0) begin
            n_fail++;
            $display("FAIL reset_results: got %h %h %h %h %h, required all 0",
                     res_index, res_hi, res_lo0, res_lo1, res_mask);
        end
    endtask

    task automatic test_random_count();
        step();
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (random !== W'(31 - i)) begin
                n_fail++;
                $display("FAIL random_count[%0d]: got %0d, required %0d", i, random, 31 - i);
            end
            step();
        end
    endtask

    task automatic test_tlbwi();
        exp_t e;
        issue(OP_TLBWI, 5'd5);
        n_checks++;
        if (tlb_write !== 1'b1 || tlb_idx !== 5'd5 || op_done !== 1'b0) begin
            n_fail++;
            $display("FAIL tlbwi_cycle1: got write=%b idx=%0d done=%b, required 1/5/0",
                     tlb_write, tlb_idx, op_done);
        end
        step();
        n_checks++;
        if (tlb_write !== 1'b0 || tlb_idx !== 5'd5 || op_done !== 1'b1 || op_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tlbwi_cycle2: got write=%b idx=%0d done=%b ready=%b, required 0/5/1/0",
                     tlb_write, tlb_idx, op_done, op_ready);
        end
        if (op_done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (idx_we !== e.idx_we || rd_we !== e.rd_we) begin
                n_fail++;
                $display("FAIL tlbwi_we: got idx_we=%b rd_we=%b, required %b/%b",
                         idx_we, rd_we, e.idx_we, e.rd_we);
            end
        end
        step();
        n_checks++;
        if (op_ready !== 1'b1 || op_done !== 1'b0) begin
            n_fail++;
            $display("FAIL tlbwi_cycle3: got ready=%b done=%b, required 1/0", op_ready, op_done);
        end
    endtask

    task automatic test_tlbp();
        exp_t e;
        logic [31:0] probes [2];
        probes[0] = 32'h0000_0007;
        probes[1] = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            probe_index = probes[i];
            issue(OP_TLBP, 5'd1);
            step();
            n_checks++;
            if (op_done !== 1'b1 || sb.size() == 0) begin
                n_fail++;
                $display("FAIL tlbp_done[%0d]: got done=%b, required 1", i, op_done);
            end else begin
                e = sb.pop_front();
                n_checks++;
                if (res_index !== e.index || idx_we !== e.idx_we || rd_we !== e.rd_we ||
                    res_hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL tlbp_result[%0d]: got index=%h idx_we=%b rd_we=%b, required %h/%b/%b",
                             i, res_index, idx_we, rd_we, e.index, e.idx_we, e.rd_we);
                end
            end
            step();
        end
    endtask

    task automatic test_tlbr();
        exp_t e;
        read_hi   = 32'h1234_5678;
        read_lo0  = 32'h0000_0017;
        read_lo1  = 32'hCAFE_0001;
        read_mask = 12'hFFF;
        issue(OP_TLBR, 5'd3);
        n_checks++;
        if (tlb_idx !== 5'd3 || tlb_write !== 1'b0) begin
            n_fail++;
            $display("FAIL tlbr_cycle1: got idx=%0d write=%b, required 3/0", tlb_idx, tlb_write);
        end
        step();
        n_checks++;
        if (op_done !== 1'b1 || sb.size() == 0) begin
            n_fail++;
            $display("FAIL tlbr_done: got done=%b, required 1", op_done);
        end else begin
            e = sb.pop_front();
            n_checks++;
            if (res_hi !== e.hi || res_lo0 !== e.lo0 || res_lo1 !== e.lo1 ||
                res_mask !== e.mask || rd_we !== e.rd_we || idx_we !== e.idx_we ||
                res_index !== e.index) begin
                n_fail++;
                $display("FAIL tlbr_result: got %h %h %h %h rd_we=%b idx=%h, required %h %h %h %h 1 %h",
                         res_hi, res_lo0, res_lo1, res_mask, rd_we, res_index,
                         e.hi, e.lo0, e.lo1, e.mask, e.index);
            end
        end
        step();
    endtask

    task automatic test_wired_and_tlbwr();
        exp_t e;
        cp0_wired = 5'd4;
        wired_we  = 1'b1;
        step();
        wired_we = 1'b0;
        for (int i = 0; i < 28; i++) begin
            n_checks++;
            if (random !== W'(31 - i)) begin
                n_fail++;
                $display("FAIL wired_count[%0d]: got %0d, required %0d", i, random, 31 - i);
            end
            step();
        end
        n_checks++;
        if (random !== 5'd31) begin
            n_fail++;
            $display("FAIL wired_wrap: got %0d, required 31", random);
        end
        step(21);
        n_checks++;
        if (random !== 5'd10) begin
            n_fail++;
            $display("FAIL wired_pre10: got %0d, required 10", random);
        end
        wired_we = 1'b1;
        step();
        wired_we = 1'b0;
        n_checks++;
        if (random !== 5'd31) begin
            n_fail++;
            $display("FAIL wired_we_reload: got %0d, required 31", random);
        end
        step(19);
        n_checks++;
        if (random !== 5'd12) begin
            n_fail++;
            $display("FAIL tlbwr_pre12: got %0d, required 12", random);
        end
        wired_we = 1'b1;
        issue(OP_TLBWR, 5'd3);
        wired_we = 1'b0;
        n_checks++;
        if (tlb_idx !== 5'd12 || tlb_write !== 1'b1 || random !== 5'd31) begin
            n_fail++;
            $display("FAIL tlbwr_idx: got idx=%0d write=%b random=%0d, required 12/1/31",
                     tlb_idx, tlb_write, random);
        end
        step();
        if (op_done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (idx_we !== e.idx_we || rd_we !== e.rd_we || res_hi !== e.hi || res_index !== e.index) begin
                n_fail++;
                $display("FAIL tlbwr_result: got idx_we=%b rd_we=%b hi=%h, required %b/%b/%h",
                         idx_we, rd_we, res_hi, e.idx_we, e.rd_we, e.hi);
            end
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL tlbwr_done: got done=%b, required 1", op_done);
        end
        step();
        cp0_wired = 5'd0;
    endtask

    task automatic test_reset_abort();
        int seen_done = 0;
        issue(OP_TLBWI, 5'd9);
        sb.delete();
        n_checks++;
        if (tlb_write !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: got write=%b, required 1", tlb_write);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (tlb_write !== 1'b0 || op_ready !== 1'b1 || random !== 5'd31 || op_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: got write=%b ready=%b random=%0d done=%b, required 0/1/31/0",
                     tlb_write, op_ready, random, op_done);
        end
        m = '0;
        step(2);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (op_done !== 1'b0 || idx_we !== 1'b0 || rd_we !== 1'b0) seen_done++;
            step();
        end
        n_checks++;
        if (seen_done != 0 || op_ready !== 1'b1 || res_index !== m.index) begin
            n_fail++;
            $display("FAIL abort_after: got done_cycles=%0d ready=%b res_index=%h, required 0/1/%h",
                     seen_done, op_ready, res_index, m.index);
        end
    endtask

    initial begin
        m = '0;
        test_reset();
        test_random_count();
        test_tlbwi();
        test_tlbp();
        test_tlbr();
        test_wired_and_tlbwr();
        test_reset_abort();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
